// File: rtl/display_buffer.sv
// Character buffer for the segmented display: cursor-driven writes, scroll on overflow,
// blanking sweep on clear, caret substitution on the scan read port.
// Build option: define DISPLAY_BUFFER_WRAP_EN to wrap the cursor instead of scrolling.
module display_buffer #(
    parameter int                DATA_W    = 8,
    parameter int                DEPTH     = 16,
    parameter int                ADDR_W    = 4,
    parameter logic [DATA_W-1:0] CARET_CHR = 8'h5F,
    parameter logic [DATA_W-1:0] BLANK_CHR = 8'h20
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_valid,
    input  logic [1:0]        i_wr_cmd,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ready,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic              i_caret_strobe,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    output logic [ADDR_W-1:0] o_cursor,
    output logic              o_full
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   CNT_END = (ADDR_W + 1)'(DEPTH);

    localparam logic [1:0] CMD_CHAR = 2'b00;
    localparam logic [1:0] CMD_BS   = 2'b01;
    localparam logic [1:0] CMD_CLR  = 2'b10;
    localparam logic [1:0] CMD_HOME = 2'b11;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cursor_q, cursor_d;
    logic                full_q, full_d;
    logic [ADDR_W:0]     clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_val;
    logic                shift_en;
    logic                caret_hit;

    // Sweep counter runs one past the last cell so the hand-back to IDLE gets its own cycle.
    always_comb begin
        state_d    = state_q;
        cursor_d   = cursor_q;
        full_d     = full_q;
        clr_cnt_d  = clr_cnt_q;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_val     = BLANK_CHR;
        shift_en   = 1'b0;
        o_wr_ready = 1'b0;
        case (state_q)
            CLEAR: begin
                if (clr_cnt_q == CNT_END) begin
                    state_d  = IDLE;
                    cursor_d = '0;
                    full_d   = 1'b0;
                end else begin
                    wr_en     = 1'b1;
                    wr_addr   = clr_cnt_q[ADDR_W-1:0];
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: begin
                o_wr_ready = 1'b1;
                if (i_wr_valid) begin
                    case (i_wr_cmd)
                        CMD_CHAR: begin
                            wr_val = i_wr_data;
`ifdef DISPLAY_BUFFER_WRAP_EN
                            wr_en    = 1'b1;
                            wr_addr  = cursor_q;
                            cursor_d = (cursor_q == LAST) ? '0 : cursor_q + ADDR_W'(1);
`else
                            if (full_q) begin
                                shift_en = 1'b1;
                            end else if (cursor_q != LAST) begin
                                wr_en    = 1'b1;
                                wr_addr  = cursor_q;
                                cursor_d = cursor_q + ADDR_W'(1);
                            end else begin
                                wr_en   = 1'b1;
                                wr_addr = LAST;
                                full_d  = 1'b1;
                            end
`endif
                        end
                        CMD_BS: begin
`ifdef DISPLAY_BUFFER_WRAP_EN
                            wr_en    = 1'b1;
                            cursor_d = (cursor_q == '0) ? LAST : cursor_q - ADDR_W'(1);
                            wr_addr  = cursor_d;
`else
                            if (full_q) begin
                                wr_en   = 1'b1;
                                wr_addr = LAST;
                                full_d  = 1'b0;
                            end else if (cursor_q != '0) begin
                                wr_en    = 1'b1;
                                cursor_d = cursor_q - ADDR_W'(1);
                                wr_addr  = cursor_d;
                            end
`endif
                        end
                        CMD_CLR: begin
                            state_d   = CLEAR;
                            clr_cnt_d = '0;
                        end
                        CMD_HOME: begin
                            cursor_d = '0;
                            full_d   = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    // Caret follows the cursor, or sits on the last cell while scrolling is armed.
    assign caret_hit = (state_q == IDLE) && !i_caret_strobe &&
                       (full_q ? (i_rd_addr == LAST) : (i_rd_addr == cursor_q));

    always_comb begin
        rd_data_d = rd_data_q;
        if (i_rd_en) begin
            if ({1'b0, i_rd_addr} >= CNT_END) begin
                rd_data_d = BLANK_CHR;
            end else if (caret_hit) begin
                rd_data_d = CARET_CHR;
            end else begin
                rd_data_d = mem_q[i_rd_addr];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= CLEAR;
            clr_cnt_q  <= '0;
            cursor_q   <= '0;
            full_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            cursor_q   <= cursor_d;
            full_q     <= full_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= i_rd_en;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (shift_en) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    mem_q[i] <= mem_q[i+1];
                end
                mem_q[DEPTH-1] <= wr_val;
            end else if (wr_en) begin
                mem_q[wr_addr] <= wr_val;
            end
        end
    end

    assign o_rd_data  = rd_data_q;
    assign o_rd_valid = rd_valid_q;
    assign o_cursor   = cursor_q;
`ifdef DISPLAY_BUFFER_WRAP_EN
    assign o_full     = 1'b0;
`else
    assign o_full     = full_q;
`endif

endmodule

// File: tb/tb_display_buffer.sv
// Directed testbench for display_buffer: reset sweep, writes, scroll, backspace,
// clear with a queued character, reset during a sweep, and wrap mode when enabled.
module tb_display_buffer;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic [1:0] wr_cmd = 2'b00;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready;
    logic       rd_en = 1'b0;
    logic [3:0] rd_addr = 4'd0;
    logic       caret_strobe = 1'b1;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [3:0] cursor;
    logic       full;

    int checks_total = 0;
    int checks_pass  = 0;

    display_buffer dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_wr_valid     (wr_valid),
        .i_wr_cmd       (wr_cmd),
        .i_wr_data      (wr_data),
        .o_wr_ready     (wr_ready),
        .i_rd_en        (rd_en),
        .i_rd_addr      (rd_addr),
        .i_caret_strobe (caret_strobe),
        .o_rd_data      (rd_data),
        .o_rd_valid     (rd_valid),
        .o_cursor       (cursor),
        .o_full         (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) checks_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] cmd, input logic [7:0] d);
        int n;
        n = 0;
        wr_valid = 1'b1;
        wr_cmd   = cmd;
        wr_data  = d;
        while (!wr_ready && n < 100) begin
            step();
            n++;
        end
        if (!wr_ready) check("send_timeout", {31'd0, wr_ready}, 32'd1);
        step();
        wr_valid = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic s, output logic [7:0] d);
        rd_en        = 1'b1;
        rd_addr      = a;
        caret_strobe = s;
        step();
        d            = rd_data;
        rd_en        = 1'b0;
        caret_strobe = 1'b1;
    endtask

    // Counts clock edges after reset release until ready rises (bounded).
    task automatic release_and_count(output int n);
        rst = 1'b0;
        n   = 0;
        do begin
            step();
            n++;
        end while (!wr_ready && n < 100);
    endtask

    logic [7:0] d;
    int         n;

    initial begin
        // Reset state
        step();
        step();
        check("rst_ready", {31'd0, wr_ready}, 32'd0);
        check("rst_cursor", {28'd0, cursor}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_rd_data", {24'd0, rd_data}, 32'd0);

        release_and_count(n);
        check("init_ready_latency", n, DEPTH + 1);
        for (int i = 0; i < DEPTH; i++) begin
            rd(4'(i), 1'b1, d);
            check($sformatf("init_blank_%0d", i), {24'd0, d}, 32'h20);
        end
        check("rd_valid_after_read", {31'd0, rd_valid}, 32'd1);
        step();
        check("rd_valid_idle", {31'd0, rd_valid}, 32'd0);
        check("init_cursor", {28'd0, cursor}, 32'd0);

        // Three characters
        send(2'b00, 8'h41);
        send(2'b00, 8'h42);
        send(2'b00, 8'h43);
        rd(4'd0, 1'b1, d); check("abc_c0", {24'd0, d}, 32'h41);
        rd(4'd1, 1'b1, d); check("abc_c1", {24'd0, d}, 32'h42);
        rd(4'd2, 1'b1, d); check("abc_c2", {24'd0, d}, 32'h43);
        rd(4'd3, 1'b1, d); check("abc_c3", {24'd0, d}, 32'h20);
        check("abc_cursor", {28'd0, cursor}, 32'd3);
        rd(4'd3, 1'b0, d); check("caret_c3", {24'd0, d}, 32'h5F);
        rd(4'd2, 1'b0, d); check("nocaret_c2", {24'd0, d}, 32'h43);

`ifdef DISPLAY_BUFFER_WRAP_EN
        send(2'b11, 8'h00);
        for (int i = 0; i < 17; i++) send(2'b00, 8'(8'h30 + i));
        rd(4'd0, 1'b1, d); check("wrap_c0", {24'd0, d}, 32'h40);
        rd(4'd1, 1'b1, d); check("wrap_c1", {24'd0, d}, 32'h31);
        check("wrap_cursor", {28'd0, cursor}, 32'd1);
        check("wrap_full", {31'd0, full}, 32'd0);
        send(2'b11, 8'h00);
        send(2'b01, 8'h00);
        check("wrap_bs_cursor", {28'd0, cursor}, 32'd15);
        rd(4'd15, 1'b1, d); check("wrap_bs_c15", {24'd0, d}, 32'h20);
`else
        // Fill, then scroll once
        send(2'b11, 8'h00);
        for (int i = 0; i < 16; i++) send(2'b00, 8'(8'h30 + i));
        check("fill_full", {31'd0, full}, 32'd1);
        check("fill_cursor", {28'd0, cursor}, 32'd15);
        send(2'b00, 8'h40);
        check("scroll_full", {31'd0, full}, 32'd1);
        check("scroll_cursor", {28'd0, cursor}, 32'd15);
        rd(4'd0, 1'b1, d);  check("scroll_c0", {24'd0, d}, 32'h31);
        rd(4'd7, 1'b1, d);  check("scroll_c7", {24'd0, d}, 32'h38);
        rd(4'd15, 1'b1, d); check("scroll_c15", {24'd0, d}, 32'h40);
        rd(4'd15, 1'b0, d); check("full_caret_c15", {24'd0, d}, 32'h5F);
        rd(4'd14, 1'b0, d); check("full_nocaret_c14", {24'd0, d}, 32'h3F);

        // Backspace from full, then from the last cell
        send(2'b01, 8'h00);
        check("bs1_full", {31'd0, full}, 32'd0);
        check("bs1_cursor", {28'd0, cursor}, 32'd15);
        rd(4'd15, 1'b1, d); check("bs1_c15", {24'd0, d}, 32'h20);
        send(2'b01, 8'h00);
        check("bs2_cursor", {28'd0, cursor}, 32'd14);
        rd(4'd14, 1'b1, d); check("bs2_c14", {24'd0, d}, 32'h20);
        rd(4'd13, 1'b1, d); check("bs2_c13", {24'd0, d}, 32'h3E);

        // Backspace at the origin does nothing
        send(2'b11, 8'h00);
        send(2'b01, 8'h00);
        check("bs0_cursor", {28'd0, cursor}, 32'd0);
        rd(4'd0, 1'b1, d); check("bs0_c0", {24'd0, d}, 32'h31);

        // Same-cycle write and read of cell 0 returns the old value
        wr_valid = 1'b1; wr_cmd = 2'b00; wr_data = 8'h55;
        rd_en = 1'b1; rd_addr = 4'd0; caret_strobe = 1'b1;
        step();
        wr_valid = 1'b0; rd_en = 1'b0;
        check("rbw_old", {24'd0, rd_data}, 32'h31);
        rd(4'd0, 1'b1, d); check("rbw_new", {24'd0, d}, 32'h55);
        check("rbw_cursor", {28'd0, cursor}, 32'd1);
`endif

        // Clear with a character queued behind it
        send(2'b10, 8'h00);
        wr_valid = 1'b1; wr_cmd = 2'b00; wr_data = 8'h77;
        n = 0;
        while (!wr_ready && n < 100) begin
            n++;
            step();
        end
        check("clear_busy_cycles", n, DEPTH + 1);
        step();
        wr_valid = 1'b0;
        rd(4'd0, 1'b1, d); check("queued_c0", {24'd0, d}, 32'h77);
        rd(4'd1, 1'b1, d); check("queued_c1", {24'd0, d}, 32'h20);
        check("queued_cursor", {28'd0, cursor}, 32'd1);

        // Reset during a sweep restarts it
        send(2'b10, 8'h00);
        repeat (4) step();
        check("midclr_ready", {31'd0, wr_ready}, 32'd0);
        rst = 1'b1;
        step();
        check("midclr_rst_cursor", {28'd0, cursor}, 32'd0);
        release_and_count(n);
        check("midclr_ready_latency", n, DEPTH + 1);
        rd(4'd0, 1'b1, d); check("midclr_c0", {24'd0, d}, 32'h20);
        check("midclr_cursor", {28'd0, cursor}, 32'd0);

        $display("%0d/%0d checks passed", checks_pass, checks_total);
        $finish;
    end

endmodule
